// File: rtl/effect_axil_regs.sv
// AXI4-Lite slave holding the effect parameter registers (gain, mix, ...).
// Define EFFECT_AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR.
module effect_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_REGS           = 4
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
   input  logic [2:0]                    S_AXI_AWPROT,
   input  logic                          S_AXI_AWVALID,
   output logic                          S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
   input  logic [3:0]                    S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
   input  logic [2:0]                    S_AXI_ARPROT,
   input  logic                          S_AXI_ARVALID,
   output logic                          S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic [NUM_REGS*32-1:0]        reg_out,
   output logic [NUM_REGS-1:0]           reg_wr_pulse
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef EFFECT_AXIL_SLVERR_EN
   localparam logic [1:0] RESP_OOR = 2'b10;
`else
   localparam logic [1:0] RESP_OOR = 2'b00;
`endif

   typedef enum logic {W_ADDR_DATA, W_RESP} w_state_e;
   typedef enum logic {R_ADDR, R_DATA} r_state_e;

   w_state_e w_state_q, w_state_d;
   r_state_e r_state_q, r_state_d;

   logic [31:0] regs_q [NUM_REGS];
   logic [31:0] regs_d [NUM_REGS];

   logic                          aw_done_q, aw_done_d;
   logic                          w_done_q, w_done_d;
   logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [31:0]                   wdata_q, wdata_d;
   logic [3:0]                    wstrb_q, wstrb_d;
   logic [1:0]                    bresp_q, bresp_d;
   logic [NUM_REGS-1:0]           pulse_q, pulse_d;
   logic [31:0]                   rdata_q, rdata_d;
   logic [1:0]                    rresp_q, rresp_d;

   logic                          aw_hs, w_hs, ar_hs, commit;
   logic [C_S_AXI_ADDR_WIDTH-1:0] waddr_eff;
   logic [31:0]                   wdata_eff;
   logic [3:0]                    wstrb_eff;
   logic [IDX_W-1:0]              widx, ridx;
   logic                          w_in_range, r_in_range;

   // Handshake readiness follows the FSM states directly.
   assign S_AXI_AWREADY = (w_state_q == W_ADDR_DATA) && !aw_done_q;
   assign S_AXI_WREADY  = (w_state_q == W_ADDR_DATA) && !w_done_q;
   assign S_AXI_BVALID  = (w_state_q == W_RESP);
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_ARREADY = (r_state_q == R_ADDR);
   assign S_AXI_RVALID  = (r_state_q == R_DATA);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign reg_wr_pulse  = pulse_q;

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

   // Bypass a same-cycle handshake so the commit needs no extra cycle.
   assign waddr_eff = aw_hs ? S_AXI_AWADDR : awaddr_q;
   assign wdata_eff = w_hs ? S_AXI_WDATA : wdata_q;
   assign wstrb_eff = w_hs ? S_AXI_WSTRB : wstrb_q;
   assign commit    = (w_state_q == W_ADDR_DATA)
                    && (aw_done_q || aw_hs) && (w_done_q || w_hs);

   assign widx = waddr_eff[C_S_AXI_ADDR_WIDTH-1:2];
   assign ridx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
   assign w_in_range = {{(32-IDX_W){1'b0}}, widx} < 32'(NUM_REGS);
   assign r_in_range = {{(32-IDX_W){1'b0}}, ridx} < 32'(NUM_REGS);

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
      assign reg_out[32*g +: 32] = regs_q[g];
   end

   // Write channel: collect AW and W, commit bytes, then hold the response.
   always_comb begin
      w_state_d = w_state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      pulse_d   = '0;
      regs_d    = regs_q;
      unique case (w_state_q)
         W_ADDR_DATA: begin
            if (commit) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (widx == IDX_W'(i)) begin
                     pulse_d[i] = 1'b1;
                     for (int b = 0; b < 4; b++) begin
                        if (wstrb_eff[b]) begin
                           regs_d[i][8*b +: 8] = wdata_eff[8*b +: 8];
                        end
                     end
                  end
               end
               bresp_d   = w_in_range ? RESP_OKAY : RESP_OOR;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               w_state_d = W_RESP;
            end else begin
               if (aw_hs) begin
                  aw_done_d = 1'b1;
                  awaddr_d  = S_AXI_AWADDR;
               end
               if (w_hs) begin
                  w_done_d = 1'b1;
                  wdata_d  = S_AXI_WDATA;
                  wstrb_d  = S_AXI_WSTRB;
               end
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) begin
               w_state_d = W_ADDR_DATA;
            end
         end
         default: w_state_d = W_ADDR_DATA;
      endcase
   end

   // Read channel: capture the pre-edge register value on AR, hold until R.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      unique case (r_state_q)
         R_ADDR: begin
            if (ar_hs) begin
               rdata_d = '0;
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (ridx == IDX_W'(i)) begin
                     rdata_d = regs_q[i];
                  end
               end
               rresp_d   = r_in_range ? RESP_OKAY : RESP_OOR;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) begin
               r_state_d = R_ADDR;
            end
         end
         default: r_state_d = R_ADDR;
      endcase
   end

   // State and register update with synchronous reset.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state_q <= W_ADDR_DATA;
         r_state_q <= R_ADDR;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RESP_OKAY;
         pulse_q   <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bresp_q   <= bresp_d;
         pulse_q   <= pulse_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         regs_q    <= regs_d;
      end
   end

   logic unused_ok;
   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_effect_axil_regs.sv
// Directed bench for effect_axil_regs: one 4-register and one 2-register
// instance share the same AXI stimulus.
module tb_effect_axil_regs;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]  awaddr = '0, araddr = '0;
   logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;

   logic        awready1, wready1, bvalid1, arready1, rvalid1;
   logic [1:0]  bresp1, rresp1;
   logic [31:0] rdata1;
   logic [127:0] regs1;
   logic [3:0]  pulse1;

   logic        awready2, wready2, bvalid2, arready2, rvalid2;
   logic [1:0]  bresp2, rresp2;
   logic [31:0] rdata2;
   logic [63:0] regs2;
   logic [1:0]  pulse2;

`ifdef EFFECT_AXIL_SLVERR_EN
   localparam logic [1:0] OOR_RESP = 2'b10;
`else
   localparam logic [1:0] OOR_RESP = 2'b00;
`endif

   effect_axil_regs u1 (
      .ACLK(clk), .ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000),
      .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready1),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready1),
      .S_AXI_BRESP(bresp1), .S_AXI_BVALID(bvalid1), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000),
      .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready1),
      .S_AXI_RDATA(rdata1), .S_AXI_RRESP(rresp1),
      .S_AXI_RVALID(rvalid1), .S_AXI_RREADY(rready),
      .reg_out(regs1), .reg_wr_pulse(pulse1)
   );

   effect_axil_regs #(.NUM_REGS(2)) u2 (
      .ACLK(clk), .ARESET(rst),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000),
      .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready2),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
      .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready2),
      .S_AXI_BRESP(bresp2), .S_AXI_BVALID(bvalid2), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000),
      .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready2),
      .S_AXI_RDATA(rdata2), .S_AXI_RRESP(rresp2),
      .S_AXI_RVALID(rvalid2), .S_AXI_RREADY(rready),
      .reg_out(regs2), .reg_wr_pulse(pulse2)
   );

   int checks = 0;
   int errors = 0;
   int pc1 [4] = '{0, 0, 0, 0};
   int pc2 = 0;

   // Count write pulses per register, sampled mid-cycle.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (pulse1[i] === 1'b1) pc1[i] <= pc1[i] + 1;
      end
      if (|pulse2 === 1'b1) pc2 <= pc2 + 1;
   end

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] s,
                            output logic [1:0] r1, output logic [1:0] r2);
      logic aw_ok, w_ok;
      int n;
      awaddr = a; wdata = d; wstrb = s;
      awvalid = 1; wvalid = 1;
      n = 0;
      while ((awvalid || wvalid) && n < 20) begin
         aw_ok = awready1;
         w_ok = wready1;
         tick();
         if (aw_ok) awvalid = 0;
         if (w_ok) wvalid = 0;
         n++;
      end
      check("wr_accept", {awvalid, wvalid}, 2'b00);
      bready = 1;
      n = 0;
      while (!bvalid1 && n < 20) begin
         tick();
         n++;
      end
      check("wr_bvalid", bvalid1, 1'b1);
      r1 = bresp1;
      r2 = bresp2;
      tick();
      bready = 0;
   endtask

   task automatic axi_read(input logic [3:0] a,
                           output logic [31:0] d1, output logic [1:0] r1,
                           output logic [31:0] d2, output logic [1:0] r2);
      logic ok;
      int n;
      araddr = a;
      arvalid = 1;
      n = 0;
      while (arvalid && n < 20) begin
         ok = arready1;
         tick();
         if (ok) arvalid = 0;
         n++;
      end
      check("rd_latency", rvalid1, 1'b1);
      d1 = rdata1; r1 = rresp1;
      d2 = rdata2; r2 = rresp2;
      rready = 1;
      tick();
      rready = 0;
   endtask

   initial begin
      logic [1:0]  r1, r2;
      logic [31:0] d1, d2;
      logic        stable;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      check("rst_ready", {awready1, wready1, arready1}, 3'b111);
      check("rst_valid", {bvalid1, rvalid1}, 2'b00);
      check("rst_resp", {bresp1, rresp1, rdata1}, '0);
      check("rst_regs", regs1, '0);
      check("rst_pulse", pulse1, 4'b0000);

      // Sequential writes then read-back
      for (int i = 0; i < 4; i++) begin
         axi_write(4'(4 * i), 32'(i + 1), 4'hF, r1, r2);
         check("seq_bresp", r1, 2'b00);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(4 * i), d1, r1, d2, r2);
         check("seq_rdata", d1, 32'(i + 1));
         check("seq_rresp", r1, 2'b00);
      end
      check("seq_regout", regs1,
            128'h00000004_00000003_00000002_00000001);
      check("seq_pulses", {pc1[0], pc1[1], pc1[2], pc1[3]},
            {32'd1, 32'd1, 32'd1, 32'd1});

      // AW three cycles ahead of W
      awaddr = 4'h4; wdata = 32'hDEADBEEF; wstrb = 4'hF;
      awvalid = 1;
      tick();
      awvalid = 0;
      check("awlead_ready", {awready1, wready1}, 2'b01);
      tick();
      tick();
      check("awlead_nobv", bvalid1, 1'b0);
      check("awlead_old", regs1[63:32], 32'h2);
      wvalid = 1;
      tick();
      wvalid = 0;
      check("awlead_bv", bvalid1, 1'b1);
      check("awlead_reg1", regs1[63:32], 32'hDEADBEEF);
      check("awlead_pulse", pulse1, 4'b0010);
      bready = 1;
      tick();
      bready = 0;
      check("awlead_rdy", {awready1, wready1}, 2'b11);

      // Byte strobes
      axi_write(4'h8, 32'h11223344, 4'hF, r1, r2);
      axi_write(4'h8, 32'hAABBCCDD, 4'b0101, r1, r2);
      axi_read(4'h8, d1, r1, d2, r2);
      check("strb_rdata", d1, 32'h11BB33DD);
      check("strb_pulses", pc1[2], 32'd3);

      // Response backpressure on both channels
      awaddr = 4'hC; wdata = 32'h99; wstrb = 4'hF; araddr = 4'h0;
      awvalid = 1; wvalid = 1; arvalid = 1;
      tick();
      awvalid = 0; wvalid = 0; arvalid = 0;
      stable = 1;
      for (int i = 0; i < 5; i++) begin
         if (!(bvalid1 && rvalid1 && rdata1 == 32'h1 && bresp1 == 2'b00
               && rresp1 == 2'b00 && !awready1 && !wready1 && !arready1))
            stable = 0;
         tick();
      end
      check("stall_stable", stable, 1'b1);
      bready = 1; rready = 1;
      tick();
      bready = 0; rready = 0;
      check("stall_done", {bvalid1, rvalid1}, 2'b00);
      check("stall_rdy", {awready1, wready1, arready1}, 3'b111);
      check("stall_reg3", regs1[127:96], 32'h99);

      // Write and read of the same register on the same edge
      axi_write(4'h8, 32'h7, 4'hF, r1, r2);
      awaddr = 4'h8; wdata = 32'h55; wstrb = 4'hF; araddr = 4'h8;
      awvalid = 1; wvalid = 1; arvalid = 1;
      tick();
      awvalid = 0; wvalid = 0; arvalid = 0;
      check("same_old", {rvalid1, rdata1}, {1'b1, 32'h7});
      check("same_reg2", regs1[95:64], 32'h55);
      bready = 1; rready = 1;
      tick();
      bready = 0; rready = 0;
      axi_read(4'h8, d1, r1, d2, r2);
      check("same_new", d1, 32'h55);

      // Out of range on the 2-register instance
      axi_write(4'h8, 32'hFFFFFFFF, 4'hF, r1, r2);
      check("oor_bresp", r2, OOR_RESP);
      check("oor_inr_bresp", r1, 2'b00);
      check("oor_regs", regs2, 64'hDEADBEEF_00000001);
      check("oor_nopulse", pc2, 32'd3);
      axi_read(4'h8, d1, r1, d2, r2);
      check("oor_rdata", d2, 32'h0);
      check("oor_rresp", r2, OOR_RESP);
      check("oor_inr_rdata", d1, 32'hFFFFFFFF);

      // Reset while a write response is pending
      awaddr = 4'h0; wdata = 32'h123; wstrb = 4'hF;
      awvalid = 1; wvalid = 1;
      tick();
      awvalid = 0; wvalid = 0;
      check("rstm_bv", bvalid1, 1'b1);
      rst = 1;
      tick();
      rst = 0;
      check("rstm_valid", {bvalid1, rvalid1}, 2'b00);
      check("rstm_regs", {regs1, regs2}, '0);
      check("rstm_rdy", {awready1, wready1, arready1}, 3'b111);
      tick();
      check("rstm_nobv", bvalid1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
